priority_encoder_scanner: RTL and testbench
===========================================

Name: priority_encoder_scanner

Overview:
- Inverse of the team's decoder tree: accepts an N-bit request vector and emits the binary index of every set bit, one per handshake, lowest index first.
- Turns a multi-hot vector back into a stream of indices, for example for serving several pending request lines.
- A decoder fed the emitted indices reproduces the accepted vector bit by bit.
- Valid/ready handshake on both sides; input is blocked while a vector is being drained.

Parameters:
- N, default 8, width of the request vector (N ≥ 2, power of two).
- W, default $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bits is valid.
- in_ready  output  1  block can accept a vector.
- in_bits  input  N  request vector.
- out_valid  output  1  out_index is valid.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  W  index of the lowest set bit still pending.
- out_last  output  1  the current beat is the final bit of the vector.
- out_remaining  output  W+1  number of set bits still pending, including the current beat.

Behaviour:
- State and storage: two states, IDLE and SCAN; one N-bit pending register.
- Reset (asynchronous, any time, including mid-scan):
  - state=IDLE, pending=0.
  - Outputs: in_ready=1, out_valid=0, out_index=0, out_last=0, out_remaining=0.
  - No partial beats after reset deasserts.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on a clk edge with in_valid && in_ready.
  - If in_bits != 0: pending <= in_bits; go to SCAN.
  - If in_bits == 0: vector consumed and discarded, no output beat, stay in IDLE.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_index = position of the lowest set bit of pending.
  - out_remaining = popcount(pending).
  - out_last = (out_remaining == 1).
  - All three are combinational from registered state only; no combinational path from any input to any output.
- Beat transfer on a clk edge with out_valid && out_ready:
  - Clear the bit at out_index in pending.
  - If out_last, go to IDLE; in_ready=1 in the following cycle.
- Stall: if out_ready=0, out_index, out_last and out_remaining hold stable and out_valid stays high.
- Latency:
  - First beat valid the cycle after acceptance.
  - One beat per cycle under continuous out_ready.
  - A vector with k set bits occupies k cycles in SCAN.
  - Throughput: one idle cycle between vectors (no accept in the cycle the last beat transfers).
- Boundaries:
  - All bits set: N beats, indices 0..N-1 in ascending order.
  - Only bit N-1 set: a single beat with out_index=N-1, out_last=1, out_remaining=1.
  - in_valid while in SCAN: ignored; in_bits is not sampled.
  - Upstream must hold in_bits until in_ready is seen.
- Width rule: out_remaining is W+1 bits so it can represent N.

Test Plan (N=8):
- Reset, then in_bits=8'b1010_0100 with out_ready=1.
  - Required: beats idx 2,5,7; out_remaining 3,2,1; out_last only on idx 7.
  - Required: in_ready low during the 3 SCAN cycles, high the next cycle.
- in_bits=8'h00 accepted.
  - Required: out_valid never asserts; in_ready stays 1; the next vector 8'h01 yields a single beat idx 0, out_last=1.
- in_bits=8'hFF with out_ready toggling 1,0,0,1,...
  - Required: 8 beats idx 0..7 in order; outputs held constant during stall cycles; no index skipped or duplicated.
- in_bits=8'h80 with out_ready=0 for 5 cycles.
  - Required: idx 7, out_last=1, out_remaining=1 stable throughout; transfers on the first out_ready=1 edge.
- rst pulsed asynchronously (mid-cycle) during the 2nd beat of 8'h0F.
  - Required: out_valid=0, in_ready=1 immediately.
  - Required: after release, vector 8'h30 yields idx 4,5 only; no leftover idx 2 or 3.
- Vector 8'h22 presented again while in SCAN with in_valid held high.
  - Required: the first vector drains as idx 1,5.
  - Required: the second copy is accepted on the cycle in_ready returns, then drains as idx 1,5.
  - Golden check: decoding the emitted indices and ORing them reproduces 8'h22 for each vector.

Source files
------------

// File: rtl/priority_encoder_scanner.sv
// rtl/priority_encoder_scanner.sv - drains a multi-hot request vector as a stream of bit indices, lowest first
`timescale 1ns/1ps

module priority_encoder_scanner #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic         out_last,
    output logic [W:0]   out_remaining
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] pending, pending_nxt;
    logic [W-1:0] low_idx;
    logic [W:0]   cnt;
    logic         found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // Lowest set bit and population count, both from registered pending only.
    always_comb begin
        low_idx = '0;
        cnt     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                if (!found) begin
                    low_idx = W'(i);
                    found   = 1'b1;
                end
                cnt = cnt + (W+1)'(1);
            end
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == SCAN);
    assign out_index     = out_valid ? low_idx : '0;
    assign out_remaining = out_valid ? cnt : '0;
    assign out_last      = out_valid && (cnt == (W+1)'(1));

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                // An all-zero vector is consumed without producing a beat.
                if (in_valid && (in_bits != '0)) begin
                    pending_nxt = in_bits;
                    state_nxt   = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_nxt[low_idx] = 1'b0;
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_priority_encoder_scanner.sv
// tb/tb_priority_encoder_scanner.sv - table-driven self-checking bench for priority_encoder_scanner
`timescale 1ns/1ps

module tb_priority_encoder_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_bits = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_index;
    logic       out_last;
    logic [3:0] out_remaining;

    int checks = 0;
    int errors = 0;

    priority_encoder_scanner #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .out_remaining(out_remaining)
    );

    always #5 clk = ~clk;

    // idx holds the expected beat indices as nibbles, beat 0 in the lowest nibble.
    typedef struct {
        logic [7:0]  bits;
        int          nbeats;
        logic [31:0] idx;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        logic [7:0] acc;
        logic [2:0] e;
        acc = 8'h00;
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_bits   = vecs[v].bits;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < vecs[v].nbeats; j++) begin
            e = 3'((vecs[v].idx >> (4 * j)) & 32'h7);
            chk("beat_valid", out_valid, 1);
            chk("beat_index", out_index, e);
            chk("beat_remaining", out_remaining, vecs[v].nbeats - j);
            chk("beat_last", out_last, (j == vecs[v].nbeats - 1) ? 1 : 0);
            chk("in_ready_during_scan", in_ready, 0);
            acc = acc | (8'd1 << out_index);
            @(negedge clk);
        end
        chk("valid_after_drain", out_valid, 0);
        chk("in_ready_after_drain", in_ready, 1);
        chk("decode_or", acc, vecs[v].bits);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         beat;
        int         c;
        logic [7:0] acc1, acc2;
        int         ev[6];
        int         ei[6];
        int         er[6];

        vecs[0] = '{8'hA4, 3, 32'h0000_0752};
        vecs[1] = '{8'h00, 0, 32'h0000_0000};
        vecs[2] = '{8'h01, 1, 32'h0000_0000};
        vecs[3] = '{8'h80, 1, 32'h0000_0007};
        vecs[4] = '{8'h30, 2, 32'h0000_0054};
        vecs[5] = '{8'h22, 2, 32'h0000_0051};
        vecs[6] = '{8'hFF, 8, 32'h7654_3210};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_remaining", out_remaining, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(v);

        // 8'hFF with out_ready pattern 1,0,0,1,0,0,...
        @(negedge clk);
        in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        beat = 0;
        c = 0;
        while (beat < 8 && c < 40) begin
            chk("ff_valid", out_valid, 1);
            chk("ff_index", out_index, beat);
            chk("ff_remaining", out_remaining, 8 - beat);
            chk("ff_last", out_last, (beat == 7) ? 1 : 0);
            out_ready = (c % 3 == 0);
            if (out_ready) beat++;
            c++;
            @(negedge clk);
        end
        chk("ff_beat_count", beat, 8);
        chk("ff_valid_after", out_valid, 0);

        // 8'h80 stalled for 5 cycles
        in_valid = 1'b1; in_bits = 8'h80; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_index", out_index, 7);
            chk("stall_last", out_last, 1);
            chk("stall_remaining", out_remaining, 1);
            if (k == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        chk("stall_done_valid", out_valid, 0);
        chk("stall_done_ready", in_ready, 1);

        // Asynchronous reset during the 2nd beat of 8'h0F
        in_valid = 1'b1; in_bits = 8'h0F; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("r_beat0", out_index, 0);
        @(negedge clk);
        chk("r_beat1", out_index, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_async_valid", out_valid, 0);
        chk("r_async_ready", in_ready, 1);
        chk("r_async_index", out_index, 0);
        chk("r_async_remaining", out_remaining, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(4);

        // 8'h22 with in_valid held high across the scan
        ev = '{1, 1, 0, 1, 1, 0};
        ei = '{1, 5, 0, 1, 5, 0};
        er = '{0, 0, 1, 0, 0, 1};
        acc1 = 8'h00;
        acc2 = 8'h00;
        @(negedge clk);
        in_valid = 1'b1; in_bits = 8'h22; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, ev[n]);
            chk("hold_index", out_index, ei[n]);
            chk("hold_in_ready", in_ready, er[n]);
            if (out_valid && n < 2) acc1 = acc1 | (8'd1 << out_index);
            if (out_valid && n >= 3) acc2 = acc2 | (8'd1 << out_index);
            if (n == 3) in_valid = 1'b0;
        end
        chk("hold_decode_first", acc1, 8'h22);
        chk("hold_decode_second", acc2, 8'h22);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
